// File: rtl/tft_pkg.sv
// Shared definitions for the TFT timing engine.
//   tft_state_e     : engine run state (IDLE / RUN / DRAIN)
//   RGB565_*        : colour-bar constants for the optional test pattern
//   tft_total()     : total period of one axis from its four segments
//   tft_bar_colour(): colour of test-pattern bar 0..7
package tft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tft_state_e;

  localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB565_RED     = 16'hF800;
  localparam logic [15:0] RGB565_BLUE    = 16'h001F;
  localparam logic [15:0] RGB565_BLACK   = 16'h0000;

  function automatic int unsigned tft_total(input int unsigned sync_w,
                                            input int unsigned back_w,
                                            input int unsigned valid_w,
                                            input int unsigned front_w);
    return sync_w + back_w + valid_w + front_w;
  endfunction

  function automatic logic [15:0] tft_bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB565_WHITE;
      3'd1:    c = RGB565_YELLOW;
      3'd2:    c = RGB565_CYAN;
      3'd3:    c = RGB565_GREEN;
      3'd4:    c = RGB565_MAGENTA;
      3'd5:    c = RGB565_RED;
      3'd6:    c = RGB565_BLUE;
      default: c = RGB565_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tft_axis_counter.sv
// One timing axis: wrapping position counter plus window decodes.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : hold the counter at zero (engine idle)
//   i_inc          : advance one position, wrapping at TOTAL-1
//   o_cnt          : current position
//   o_last         : position is TOTAL-1
//   o_sync         : position < SYNC_LEN
//   o_win          : position in [WIN_START, WIN_START+WIN_LEN)
//   o_req_win      : position in [REQ_START, REQ_START+WIN_LEN)
module tft_axis_counter #(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned TOTAL     = 16,
  parameter int unsigned SYNC_LEN  = 4,
  parameter int unsigned WIN_START = 6,
  parameter int unsigned WIN_LEN   = 8,
  parameter int unsigned REQ_START = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_sync,
  output logic             o_win,
  output logic             o_req_win
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_pos;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_pos     = 32'(r_cnt);
    o_cnt     = r_cnt;
    o_last    = (r_cnt == LAST);
    o_sync    = (w_pos < SYNC_LEN);
    o_win     = (w_pos >= WIN_START) && (w_pos < WIN_START + WIN_LEN);
    o_req_win = (w_pos >= REQ_START) && (w_pos < REQ_START + WIN_LEN);
  end

endmodule

// File: rtl/tft_timing_engine.sv
// RGB565 TFT panel timing generator with pixel-fetch request lead.
//   tft_clock_9m / system_reset_n : pixel clock, synchronous active-low reset
//   enable        : run request; dropping it lets the current frame finish
//   glyph_data    : pixel returned REQ_LEAD clocks after pix_req
//   rgb_tft, tft_data_enable, horizontal_sync, vertical_sync, tft_clock,
//   tft_background_light : panel side
//   pix_req, pix_x, pix_y : fetch request and coordinates (all-ones when idle)
//   frame_start, line_start : single-cycle pulses at h=0 (and v=0)
//   frame_cnt     : completed frames, wrapping
//   busy          : engine not idle
// Optional build macro TFT_TEST_PATTERN_EN adds input pattern_en selecting an
// eight-bar colour test pattern in place of glyph_data.
module tft_timing_engine
  import tft_pkg::*;
#(
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BACK   = 2,
  parameter int unsigned H_VALID  = 480,
  parameter int unsigned H_FRONT  = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BACK   = 2,
  parameter int unsigned V_VALID  = 272,
  parameter int unsigned V_FRONT  = 2,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             tft_clock_9m,
  input  logic             system_reset_n,
  input  logic             enable,
  input  logic [15:0]      glyph_data,
  output logic [15:0]      rgb_tft,
  output logic             horizontal_sync,
  output logic             vertical_sync,
  output logic             tft_clock,
  output logic             tft_data_enable,
  output logic             tft_background_light,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             line_start,
  output logic [15:0]      frame_cnt,
  output logic             busy
`ifdef TFT_TEST_PATTERN_EN
  ,
  input  logic             pattern_en
`endif
);

  localparam int unsigned H_TOTAL = tft_total(H_SYNC, H_BACK, H_VALID, H_FRONT);
  localparam int unsigned V_TOTAL = tft_total(V_SYNC, V_BACK, V_VALID, V_FRONT);
  localparam int unsigned H_DE    = H_SYNC + H_BACK;
  localparam int unsigned V_DE    = V_SYNC + V_BACK;

  if (H_DE < REQ_LEAD) begin : g_lead_err
    $error("H_SYNC+H_BACK must be at least REQ_LEAD");
  end
  if (REQ_LEAD < 1 || REQ_LEAD > 4) begin : g_lead_range_err
    $error("REQ_LEAD must be 1..4");
  end
  if (64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_total_err
    $error("axis total exceeds counter range");
  end

  tft_state_e       r_state, w_next;
  logic             w_run;
  logic [CNT_W-1:0] w_h, w_v;
  logic             w_h_last, w_h_sync, w_h_win, w_h_req;
  logic             w_v_last, w_v_sync, w_v_win, w_v_req;
  logic             w_frame_last;
  logic [15:0]      r_frame_cnt;

  tft_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(H_TOTAL), .SYNC_LEN(H_SYNC),
    .WIN_START(H_DE), .WIN_LEN(H_VALID), .REQ_START(H_DE - REQ_LEAD)
  ) u_h_cnt (
    .i_clk(tft_clock_9m), .i_rst_n(system_reset_n),
    .i_clr(~w_run), .i_inc(w_run),
    .o_cnt(w_h), .o_last(w_h_last), .o_sync(w_h_sync),
    .o_win(w_h_win), .o_req_win(w_h_req)
  );

  // Rows share the same window for data enable and fetch request.
  tft_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(V_TOTAL), .SYNC_LEN(V_SYNC),
    .WIN_START(V_DE), .WIN_LEN(V_VALID), .REQ_START(V_DE)
  ) u_v_cnt (
    .i_clk(tft_clock_9m), .i_rst_n(system_reset_n),
    .i_clr(~w_run), .i_inc(w_run & w_h_last),
    .o_cnt(w_v), .o_last(w_v_last), .o_sync(w_v_sync),
    .o_win(w_v_win), .o_req_win(w_v_req)
  );

  assign w_frame_last = w_h_last & w_v_last;

  always_ff @(posedge tft_clock_9m) begin
    if (!system_reset_n) r_state <= ST_IDLE;
    else                 r_state <= w_next;
  end

  // A re-asserted enable in DRAIN resumes RUN on the spot; counters never
  // stop while not idle, so there is no jump on re-entry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_next = ST_RUN;
      ST_RUN:   if (!enable) w_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)            w_next = ST_RUN;
        else if (w_frame_last) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run = (r_state != ST_IDLE);
  end

  always_ff @(posedge tft_clock_9m) begin
    if (!system_reset_n)          r_frame_cnt <= '0;
    else if (w_run && w_frame_last) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

`ifdef TFT_TEST_PATTERN_EN
  logic [CNT_W-1:0] w_col;
  logic [2:0]       w_bar;
  always_comb begin
    w_col = w_h - CNT_W'(H_DE);
    w_bar = 3'((32'(w_col) * 32'd8) / H_VALID);
  end
`endif

  always_comb begin
    tft_clock            = tft_clock_9m;
    busy                 = w_run;
    tft_background_light = w_run;
    frame_cnt            = r_frame_cnt;
    horizontal_sync      = (w_run && w_h_sync) ? SYNC_POL : ~SYNC_POL;
    vertical_sync        = (w_run && w_v_sync) ? SYNC_POL : ~SYNC_POL;
    tft_data_enable      = w_run & w_h_win & w_v_win;
    line_start           = w_run && (w_h == '0);
    frame_start          = w_run && (w_h == '0) && (w_v == '0);
`ifdef TFT_TEST_PATTERN_EN
    pix_req = w_run & w_h_req & w_v_req & ~pattern_en;
    rgb_tft = !tft_data_enable ? '0 : (pattern_en ? tft_bar_colour(w_bar) : glyph_data);
`else
    pix_req = w_run & w_h_req & w_v_req;
    rgb_tft = tft_data_enable ? glyph_data : '0;
`endif
    pix_x = pix_req ? w_h - CNT_W'(H_DE - REQ_LEAD) : '1;
    pix_y = pix_req ? w_v - CNT_W'(V_DE) : '1;
  end

endmodule

// File: tb/tb_tft_timing_engine.sv
module tb_tft_timing_engine;

  localparam int HS = 4, HB = 2, HV = 8, HF = 2;
  localparam int VS = 2, VB = 1, VV = 4, VF = 1;
  localparam int HT = HS + HB + HV + HF;   // 16
  localparam int VT = VS + VB + VV + VF;   // 8
  localparam int FT = HT * VT;             // 128
  localparam int LEAD = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] glyph = '0;
  logic        pat = 1'b0;

  logic [15:0] rgb_tft, frame_cnt;
  logic        hsync, vsync, tclk, de, bl, pix_req, fs, ls, busy;
  logic [9:0]  pix_x, pix_y;

  always #5 clk = ~clk;

  tft_timing_engine #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .SYNC_POL(1'b1), .REQ_LEAD(LEAD), .CNT_W(10)
  ) dut (
    .tft_clock_9m(clk), .system_reset_n(rst_n), .enable(enable),
    .glyph_data(glyph), .rgb_tft(rgb_tft),
    .horizontal_sync(hsync), .vertical_sync(vsync), .tft_clock(tclk),
    .tft_data_enable(de), .tft_background_light(bl), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(fs), .line_start(ls),
    .frame_cnt(frame_cnt),
`ifdef TFT_TEST_PATTERN_EN
    .pattern_en(pat),
`endif
    .busy(busy)
  );

  typedef struct packed {
    logic [15:0] rgb;
    logic        hs, vs, de, bl, req;
    logic [9:0]  px, py;
    logic        fs, ls;
    logic [15:0] fc;
    logic        busy, tclk;
  } obs_t;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  obs_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: mode 0 idle / 1 run / 2 drain, linear frame position.
  int          m_mode = 0;
  int          m_p = 0;
  logic [15:0] m_fc = '0;

  function automatic obs_t model_out(input int mode, input int p, input logic [15:0] fc,
                                     input logic [15:0] g, input logic pt);
    obs_t o;
    int h, v;
    bit run, d, rq, rows;
    h    = p % HT;
    v    = p / HT;
    run  = (mode != 0);
    rows = (v >= VS + VB) && (v < VS + VB + VV);
    d    = run && rows && (h >= HS + HB) && (h < HS + HB + HV);
    rq   = run && !pt && rows && (h >= HS + HB - LEAD) && (h < HS + HB + HV - LEAD);
    o.rgb  = !d ? 16'h0 : (pt ? bars[h - (HS + HB)] : g);
    o.hs   = run && (h < HS);
    o.vs   = run && (v < VS);
    o.de   = d;
    o.bl   = run;
    o.req  = rq;
    o.px   = rq ? 10'(h - (HS + HB - LEAD)) : 10'h3FF;
    o.py   = rq ? 10'(v - (VS + VB)) : 10'h3FF;
    o.fs   = run && (p == 0);
    o.ls   = run && (h == 0);
    o.fc   = fc;
    o.busy = run;
    o.tclk = 1'b0;
    return o;
  endfunction

  task automatic model_step();
    bit last;
    last = (m_p == FT - 1);
    if (!rst_n) begin
      m_mode = 0; m_p = 0; m_fc = '0;
    end else if (m_mode == 0) begin
      if (enable) m_mode = 1;
    end else begin
      if (last) m_fc = m_fc + 16'd1;
      m_p = (m_p + 1) % FT;
      if (m_mode == 1) begin
        if (!enable) m_mode = 2;
      end else begin
        if (enable)    m_mode = 1;
        else if (last) m_mode = 0;
      end
    end
  endtask

  task automatic tick(input logic rst, input logic en);
    @(posedge clk);
    model_step();
    #1;
    rst_n  = rst;
    enable = en;
    glyph  = 16'($urandom);
    q.push_back(model_out(m_mode, m_p, m_fc, glyph, pat));
  endtask

  task automatic reach(input bit ok, input string nm);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got condition=0 required=1 (mode=%0d pos=%0d fc=%0d)", nm, m_mode, m_p, m_fc);
    end
  endtask

  // Monitor: the DUT presents a full output set every clock.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {rgb_tft, hsync, vsync, de, bl, pix_req, pix_x, pix_y, fs, ls, frame_cnt, busy, tclk};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got rgb=%h hs=%b vs=%b de=%b bl=%b req=%b px=%h py=%h fs=%b ls=%b fc=%h busy=%b clk=%b required rgb=%h hs=%b vs=%b de=%b bl=%b req=%b px=%h py=%h fs=%b ls=%b fc=%h busy=%b clk=%b",
                   $time, a.rgb, a.hs, a.vs, a.de, a.bl, a.req, a.px, a.py, a.fs, a.ls, a.fc, a.busy, a.tclk,
                   e.rgb, e.hs, e.vs, e.de, e.bl, e.req, e.px, e.py, e.fs, e.ls, e.fc, e.busy, e.tclk);
        end
      end
    end
  end

  initial begin
    logic en_r;
    repeat (3) tick(1'b0, 1'b0);
    // Release reset with enable high, run into the second frame.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (m_fc == 16'd1 && m_p == 2 * HT) break;
      tick(1'b1, 1'b1);
    end
    reach(m_fc == 16'd1 && m_p == 2 * HT, "reach_v2");
    // Drop enable mid-frame: the frame must complete, then idle.
    for (int i = 0; i < 300; i++) begin
      if (m_mode == 0) break;
      tick(1'b1, 1'b0);
    end
    reach(m_mode == 0 && m_fc == 16'd2, "drain_to_idle");
    repeat (5) tick(1'b1, 1'b0);
    // Drain then resume before the frame ends.
    for (int i = 0; i < 200; i++) begin
      if (m_p == 2 * HT + 8) break;
      tick(1'b1, 1'b1);
    end
    reach(m_p == 2 * HT + 8, "reach_resume_point");
    repeat (20) tick(1'b1, 1'b0);
    repeat (30) tick(1'b1, 1'b1);
    // Reset mid-frame around h=9, v=4.
    for (int i = 0; i < 300; i++) begin
      if (m_p == 4 * HT + 8) break;
      tick(1'b1, 1'b1);
    end
    reach(m_p == 4 * HT + 8, "reach_reset_point");
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    // Randomised traffic.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
`ifdef TFT_TEST_PATTERN_EN
      if ($urandom_range(0, 99) == 0) pat = ~pat;
`endif
      tick(($urandom_range(0, 299) != 0), en_r);
    end
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    reach(q.size() == 0, "scoreboard_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tft_timing_engine.md
TFT_TIMING_ENGINE -- requirements
Module: tft_timing_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_SYNC 41: hsync width, clocks
- H_BACK 2: h back porch
- H_VALID 480: active columns
- H_FRONT 2: h front porch
- V_SYNC 10: vsync width, lines
- V_BACK 2: v back porch
- V_VALID 272: active rows
- V_FRONT 2: v front porch
- SYNC_POL 1: active level of hsync/vsync
- REQ_LEAD 1: pix_req lead over tft_data_enable, 1..4 clocks
- CNT_W 10: counter/coordinate width
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; one clock, synchronous active-low reset:
- tft_clock_9m  in  1  pixel clock
- system_reset_n  in  1  synchronous active-low reset
- enable  in  1  run request
- glyph_data  in  16  RGB565 pixel, REQ_LEAD clocks after pix_req
- rgb_tft  out  16  panel data
- horizontal_sync / vertical_sync  out  1  syncs at SYNC_POL
- tft_clock  out  1  = tft_clock_9m
- tft_data_enable  out  1  active-pixel strobe
- tft_background_light  out  1  backlight
- pix_req  out  1  fetch request
- pix_x / pix_y  out  CNT_W  fetch coordinates, all-ones when pix_req=0
- frame_start / line_start  out  1  single-cycle pulses
- frame_cnt  out  16  completed-frame count
- busy  out  1  state != IDLE

Function
REQ-003 SHALL derive H_TOTAL and V_TOTAL as the sums of the four per-axis parameters, with a compile-time error if H_SYNC+H_BACK < REQ_LEAD or a total exceeds 2^CNT_W.
REQ-004 SHALL implement states IDLE, RUN and DRAIN, with IDLE->RUN when enable=1, RUN->DRAIN when enable=0, DRAIN->RUN when enable=1, and DRAIN->IDLE at the last clock of a frame (h=H_TOTAL-1, v=V_TOTAL-1).
REQ-005 SHALL hold h=v=0 in IDLE and increment h every clock in RUN/DRAIN, with h wrapping at H_TOTAL-1 and v incrementing on h wrap and wrapping at V_TOTAL-1.
REQ-006 SHALL assert horizontal_sync for h<H_SYNC and vertical_sync for v<V_SYNC, at SYNC_POL level, and drive both at !SYNC_POL in IDLE.
REQ-007 SHALL assert tft_data_enable for h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID), in RUN/DRAIN only.
REQ-008 SHALL assert pix_req over the same window as tft_data_enable shifted REQ_LEAD clocks earlier in h, with pix_x = h-(H_SYNC+H_BACK-REQ_LEAD) and pix_y = v-(V_SYNC+V_BACK).
REQ-009 SHALL drive rgb_tft = glyph_data while tft_data_enable=1 and 0 otherwise.
REQ-010 SHALL pulse line_start when h=0 and frame_start when h=0 and v=0, in RUN/DRAIN only.
REQ-011 SHALL increment frame_cnt (wrapping, 16-bit) on each DRAIN->IDLE transition and on each frame wrap in RUN.
REQ-012 SHALL drive tft_background_light = busy and tft_clock = tft_clock_9m.
REQ-013 SHALL, when enable toggles within a frame, never truncate that frame: DRAIN always completes it, and re-entry to RUN continues without a counter jump.

Reset
REQ-014 SHALL, while system_reset_n=0 at a clock edge, enter IDLE with h=v=0, frame_cnt=0, all pulses/enables/rgb_tft/backlight=0, syncs=!SYNC_POL and pix_x/pix_y all-ones, including when reset arrives mid-frame.

Configuration
REQ-015 SHALL, with TFT_TEST_PATTERN_EN defined, add input pattern_en (1 bit), and when pattern_en=1 drive rgb_tft during tft_data_enable with eight equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black, by column), ignore glyph_data and hold pix_req=0.
REQ-016 SHALL, without TFT_TEST_PATTERN_EN, omit pattern_en and the bar logic entirely.

Structure
REQ-017 SHALL place the state enum, RGB565 bar colour constants and the total-derivation function in package tft_pkg.
REQ-018 SHALL use one sub-module, tft_axis_counter (counter, wrap and window decode), instantiated once per axis.

Verification (params H 4/2/8/2, V 2/1/4/1, REQ_LEAD 1, SYNC_POL 1; frame = 128 clocks)
REQ-019 SHALL cover: reset release with enable=1 -> RUN next clock; first RUN clock has frame_start=1, horizontal_sync=1, vertical_sync=1.
REQ-020 SHALL cover: v=3, h=5 -> pix_req=1 with pix_x=0, pix_y=0; h=6 -> tft_data_enable=1 and rgb_tft=glyph_data; h=14 -> enable=0, rgb_tft=0.
REQ-021 SHALL cover: enable dropped at v=2 -> DRAIN; frame completes; IDLE after h=15, v=7; frame_cnt +1; backlight=0.
REQ-022 SHALL cover: in DRAIN, enable reasserted before frame end -> RUN with no counter discontinuity.
REQ-023 SHALL cover: reset at h=9, v=4 -> next clock is IDLE with all REQ-014 values.
REQ-024 SHALL cover, with TFT_TEST_PATTERN_EN and pattern_en=1: column 0 = 16'hFFFF, column 7 = 16'h0000 (bar width 1), pix_req held 0.
